// File: rtl/bexkat1_wb_pkg.sv
// Shared definitions for the bexkat1p Wishbone memory responders.
// Holds bus widths, the read-latency ceiling, and the per-request tag that
// travels through the latency pipeline.
package bexkat1_wb_pkg;

  localparam int unsigned WB_DW      = 32;
  localparam int unsigned WB_SELW    = 4;
  localparam int unsigned RD_LAT_MAX = 4;

  // Tag carried alongside each in-flight request.
  typedef struct packed {
    logic we;
    logic err;
  } wb_req_t;

endpackage

// File: rtl/wb_lat_pipe.sv
// Fixed-latency valid/tag shift register.
// A request entering at in_valid in cycle t appears on out_valid in cycle
// t+RD_LAT. flush synchronously drops every in-flight entry.
// Ports:
//   clk_i, reset_n      clock, asynchronous active-low reset
//   flush               drop all entries at the next edge
//   in_valid, in_req    entry to load into stage 0
//   out_valid, out_req  last-stage entry
module wb_lat_pipe
  import bexkat1_wb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic    clk_i,
  input  logic    reset_n,
  input  logic    flush,
  input  logic    in_valid,
  input  wb_req_t in_req,
  output logic    out_valid,
  output wb_req_t out_req
);

  logic [RD_LAT-1:0] valid_q;
  wb_req_t           req_q [RD_LAT];

  // Shift every stage each clock; flush only needs to kill the valids.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) req_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      req_q[0]   <= in_req;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        req_q[i]   <= req_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_req   = req_q[RD_LAT-1];

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 slave in front of one synchronous SRAM port.
// Requests are issued to memory in the accept cycle and acked in order
// RD_LAT cycles later; at most DEPTH requests may be outstanding, beyond
// which the slave stalls. Dropping wb_cyc_i abandons everything in flight.
// Optional: define WB_RESP_ERR_EN to add wb_err_o; requests whose address
// bits above the memory range are nonzero then complete with an error
// instead of an ack and never write memory.
// Ports:
//   clk_i, reset_n                 clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i    Wishbone cycle / strobe / write enable
//   wb_adr_i, wb_sel_i, wb_dat_i   byte address, lane selects, write data
//   wb_dat_o, wb_ack_o, wb_stall_o read data, completion, stall
//   wb_err_o                       error completion (WB_RESP_ERR_EN only)
//   mem_addr_o, mem_wren_o         SRAM word address, write strobe
//   mem_byteena_o, mem_data_o      SRAM byte enables, write data
//   mem_q_i                        SRAM read data, RD_LAT cycles after address
module wb_mem_responder
  import bexkat1_wb_pkg::*;
#(
  parameter int unsigned AW     = 15,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic               clk_i,
  input  logic               reset_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_stall_o,
`ifdef WB_RESP_ERR_EN
  output logic               wb_err_o,
`endif
  output logic [AW-1:0]      mem_addr_o,
  output logic               mem_wren_o,
  output logic [WB_SELW-1:0] mem_byteena_o,
  output logic [WB_DW-1:0]   mem_data_o,
  input  logic [WB_DW-1:0]   mem_q_i
);

  // Out-of-range latency settings are pinned to the legal window.
  localparam int unsigned LAT = (RD_LAT < 1) ? 1 :
                                ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          addr_err;
  logic          exit_valid;
  logic          exit_done;
  wb_req_t       in_req;
  wb_req_t       exit_req;
  logic          unused_bits;

  // Stall depends only on the registered count.
  assign wb_stall_o = (cnt_q == CW'(DEPTH));
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;

`ifdef WB_RESP_ERR_EN
  assign addr_err = |wb_adr_i[31:AW+2];
`else
  assign addr_err = 1'b0;
`endif

  // Memory is driven in the accept cycle; errored writes never reach it.
  assign mem_addr_o    = wb_adr_i[AW+1:2];
  assign mem_data_o    = wb_dat_i;
  assign mem_byteena_o = wb_sel_i;
  assign mem_wren_o    = accept & wb_we_i & ~addr_err;

  assign in_req = '{we: wb_we_i, err: addr_err};

  wb_lat_pipe #(
    .RD_LAT (LAT)
  ) u_pipe (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .flush     (~wb_cyc_i),
    .in_valid  (accept),
    .in_req    (in_req),
    .out_valid (exit_valid),
    .out_req   (exit_req)
  );

  // A request leaves the pipe as either an ack or an error, never while
  // the cycle is abandoned.
  assign exit_done = exit_valid & wb_cyc_i;
  assign wb_ack_o  = exit_done & ~exit_req.err;
  assign wb_dat_o  = wb_ack_o ? mem_q_i : '0;

`ifdef WB_RESP_ERR_EN
  assign wb_err_o = exit_done & exit_req.err;
`endif

  // Outstanding-request count; an abort discards everything.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!wb_cyc_i) begin
      cnt_q <= '0;
    end else begin
      case ({accept, exit_done})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Address byte offset and the write tag are not needed by the datapath.
  assign unused_bits = ^{wb_adr_i[1:0], wb_adr_i[31:AW+2], exit_req.we};

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (DEPTH 4 and DEPTH 2, RD_LAT 2)
// each behind a behavioural SRAM. A scoreboard queue per instance receives
// the expected completion (due cycle, data) at accept time and is checked
// against wb_ack_o / wb_dat_o when the completion falls due.
module tb_wb_mem_responder;
  import bexkat1_wb_pkg::*;

  localparam int unsigned LAT = 2;

  typedef struct {
    int          due;
    logic        we;
    logic        err;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we_s;
  logic [31:0] adr_s;
  logic [3:0]  sel_s;
  logic [31:0] dat_s;
  logic [31:0] mem_q [2];

  logic [31:0] dat_o [2];
  logic        ack [2];
  logic        stall [2];
  logic        err_o [2];
  logic [14:0] maddr [2];
  logic        wren [2];
  logic [3:0]  be [2];
  logic [31:0] mdata [2];

  logic [31:0] mem  [2][64];
  logic [31:0] gold [2][64];
  logic [31:0] rp   [2][LAT];
  logic        cap_wren [2];
  logic [5:0]  cap_ix [2];
  logic [3:0]  cap_be [2];
  logic [31:0] cap_data [2];

  sb_t sbq [2][$];
  int  mcnt [2];
  int  ack_cnt [2];
  int  acc_cnt [2];
  int  wren_cnt [2];
  logic stall_seen [2];
  logic last_acc [2];
  int  cyc_no;
  int  total;
  int  bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_mem_responder #(
      .AW     (15),
      .RD_LAT (LAT),
      .DEPTH  ((g == 0) ? 4 : 2)
    ) u_dut (
      .clk_i         (clk),
      .reset_n       (reset_n),
      .wb_cyc_i      (cyc[g]),
      .wb_stb_i      (stb[g]),
      .wb_we_i       (we_s),
      .wb_adr_i      (adr_s),
      .wb_sel_i      (sel_s),
      .wb_dat_i      (dat_s),
      .wb_dat_o      (dat_o[g]),
      .wb_ack_o      (ack[g]),
      .wb_stall_o    (stall[g]),
`ifdef WB_RESP_ERR_EN
      .wb_err_o      (err_o[g]),
`endif
      .mem_addr_o    (maddr[g]),
      .mem_wren_o    (wren[g]),
      .mem_byteena_o (be[g]),
      .mem_data_o    (mdata[g]),
      .mem_q_i       (mem_q[g])
    );
`ifndef WB_RESP_ERR_EN
    assign err_o[g] = 1'b0;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input int g);
    return (g == 0) ? 4 : 2;
  endfunction

  // Per-cycle scoreboard / protocol model, evaluated mid-cycle.
  task automatic check();
    for (int g = 0; g < 2; g++) begin
      logic        aerr;
      logic        exp_stall;
      logic        acc;
      logic        exp_valid;
      sb_t         e;
      logic [5:0]  ix;
      ix   = adr_s[7:2];
`ifdef WB_RESP_ERR_EN
      aerr = |adr_s[31:17];
`else
      aerr = 1'b0;
`endif
      cap_wren[g] = wren[g];
      cap_ix[g]   = maddr[g][5:0];
      cap_be[g]   = be[g];
      cap_data[g] = mdata[g];
      last_acc[g] = 1'b0;
      if (!reset_n) begin
        chk($sformatf("d%0d_rst_ack", g), 32'(ack[g]), 32'd0);
        chk($sformatf("d%0d_rst_stall", g), 32'(stall[g]), 32'd0);
        chk($sformatf("d%0d_rst_dat", g), dat_o[g], 32'd0);
        chk($sformatf("d%0d_rst_wren", g), 32'(wren[g]), 32'd0);
        chk($sformatf("d%0d_rst_err", g), 32'(err_o[g]), 32'd0);
        sbq[g].delete();
        mcnt[g] = 0;
      end else begin
        exp_stall = (mcnt[g] == depth_of(g));
        chk($sformatf("d%0d_stall", g), 32'(stall[g]), 32'(exp_stall));
        acc = cyc[g] & stb[g] & ~exp_stall;
        chk($sformatf("d%0d_wren", g), 32'(wren[g]), 32'(acc & we_s & ~aerr));

        exp_valid = cyc[g] && (sbq[g].size() != 0) && (sbq[g][0].due == cyc_no);
        e = exp_valid ? sbq[g][0] : '{0, 1'b0, 1'b0, 32'd0};
        chk($sformatf("d%0d_ack", g), 32'(ack[g]), 32'(exp_valid & ~e.err));
        chk($sformatf("d%0d_err", g), 32'(err_o[g]), 32'(exp_valid & e.err));
        if (ack[g] && exp_valid && !e.we)
          chk($sformatf("d%0d_rdata", g), dat_o[g], e.data);
        if (!ack[g])
          chk($sformatf("d%0d_dat_idle", g), dat_o[g], 32'd0);
        if (exp_valid) void'(sbq[g].pop_front());
        if (ack[g]) ack_cnt[g]++;
        if (stall[g]) stall_seen[g] = 1'b1;
        if (wren[g]) wren_cnt[g]++;

        if (acc) begin
          chk($sformatf("d%0d_maddr", g), 32'(maddr[g]), 32'(adr_s[16:2]));
          chk($sformatf("d%0d_be", g), 32'(be[g]), 32'(sel_s));
          chk($sformatf("d%0d_mdata", g), mdata[g], dat_s);
          sbq[g].push_back('{cyc_no + int'(LAT), we_s, aerr, gold[g][ix]});
          acc_cnt[g]++;
          last_acc[g] = 1'b1;
          if (we_s && !aerr)
            for (int b = 0; b < 4; b++)
              if (sel_s[b]) gold[g][ix][b*8 +: 8] = dat_s[b*8 +: 8];
        end

        if (!cyc[g]) begin
          mcnt[g] = 0;
          sbq[g].delete();
        end else begin
          mcnt[g] = mcnt[g] + int'(acc) - int'(exp_valid);
        end
      end
    end
  endtask

  // One clock: check mid-cycle, then advance the SRAM models at the edge.
  task automatic tick();
    @(negedge clk);
    check();
    @(posedge clk);
    cyc_no++;
    for (int g = 0; g < 2; g++) begin
      for (int s = int'(LAT) - 1; s > 0; s--) rp[g][s] = rp[g][s-1];
      rp[g][0] = mem[g][cap_ix[g]];
      if (cap_wren[g])
        for (int b = 0; b < 4; b++)
          if (cap_be[g][b]) mem[g][cap_ix[g]][b*8 +: 8] = cap_data[g][b*8 +: 8];
      mem_q[g] = rp[g][LAT-1];
    end
    #1;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic req(input int g, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    cyc[g] = 1'b1;
    stb[g] = 1'b1;
    we_s = we; adr_s = adr; dat_s = dat; sel_s = sel;
    while (!done && n < 16) begin
      tick();
      done = last_acc[g];
      n++;
    end
    chk($sformatf("d%0d_req_accepted", g), 32'(done), 32'd1);
    stb[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int a0;
    total = 0; bad = 0; cyc_no = 0;
    reset_n = 1'b0;
    we_s = 1'b0; adr_s = '0; sel_s = 4'hF; dat_s = '0;
    for (int g = 0; g < 2; g++) begin
      cyc[g] = 1'b0; stb[g] = 1'b0; mem_q[g] = '0;
      mcnt[g] = 0; ack_cnt[g] = 0; acc_cnt[g] = 0; wren_cnt[g] = 0;
      stall_seen[g] = 1'b0; last_acc[g] = 1'b0;
      for (int s = 0; s < int'(LAT); s++) rp[g][s] = '0;
      for (int i = 0; i < 64; i++) begin
        mem[g][i]  = 32'h1000_0000 + 32'(i);
        gold[g][i] = 32'h1000_0000 + 32'(i);
      end
      mem[g][16] = 32'hDEAD_BEEF; gold[g][16] = 32'hDEAD_BEEF;
      mem[g][32] = 32'hAAAA_AAAA; gold[g][32] = 32'hAAAA_AAAA;
    end

    // Reset values.
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Single read of word 0x10.
    cyc[0] = 1'b1;
    a0 = ack_cnt[0];
    req(0, 1'b0, 32'h40, 32'h0, 4'hF);
    idle(4);
    chk("single_ack_count", 32'(ack_cnt[0] - a0), 32'd1);

    // Four back-to-back reads, DEPTH 4: no stall.
    stall_seen[0] = 1'b0;
    a0 = ack_cnt[0];
    for (int i = 0; i < 4; i++) req(0, 1'b0, 32'(i * 4), 32'h0, 4'hF);
    idle(4);
    chk("burst_no_stall", 32'(stall_seen[0]), 32'd0);
    chk("burst_ack_count", 32'(ack_cnt[0] - a0), 32'd4);
    cyc[0] = 1'b0;
    idle(1);

    // Saturation on the DEPTH 2 instance.
    cyc[1] = 1'b1;
    a0 = ack_cnt[1];
    for (int i = 0; i < 5; i++) req(1, 1'b0, 32'(i * 4 + 8), 32'h0, 4'hF);
    idle(5);
    chk("sat_stall_seen", 32'(stall_seen[1]), 32'd1);
    chk("sat_ack_count", 32'(ack_cnt[1] - a0), 32'd5);
    chk("sat_acc_vs_ack", 32'(acc_cnt[1]), 32'(ack_cnt[1]));
    cyc[1] = 1'b0;
    idle(1);

    // Partial write then readback.
    cyc[0] = 1'b1;
    wren_cnt[0] = 0;
    a0 = ack_cnt[0];
    req(0, 1'b1, 32'h80, 32'h1234_5678, 4'b0011);
    req(0, 1'b0, 32'h80, 32'h0, 4'hF);
    idle(4);
    chk("wr_wren_pulses", 32'(wren_cnt[0]), 32'd1);
    chk("wr_mem_word", mem[0][32], 32'hAAAA_5678);
    chk("wr_ack_count", 32'(ack_cnt[0] - a0), 32'd2);

    // Abort with requests in flight.
    for (int i = 0; i < 3; i++) req(0, 1'b0, 32'(i * 4 + 16), 32'h0, 4'hF);
    idle(1);
    cyc[0] = 1'b0;
    idle(2);
    cyc[0] = 1'b1;
    a0 = ack_cnt[0];
    idle(3);
    chk("abort_no_late_ack", 32'(ack_cnt[0] - a0), 32'd0);
    req(0, 1'b0, 32'h40, 32'h0, 4'hF);
    idle(3);
    chk("abort_new_read_ack", 32'(ack_cnt[0] - a0), 32'd1);

    // Reset with two reads in flight.
    req(0, 1'b0, 32'h0, 32'h0, 4'hF);
    req(0, 1'b0, 32'h4, 32'h0, 4'hF);
    a0 = ack_cnt[0];
    reset_n = 1'b0;
    #1;
    chk("rst_async_ack", 32'(ack[0]), 32'd0);
    idle(1);
    reset_n = 1'b1;
    idle(4);
    chk("rst_no_ack_after", 32'(ack_cnt[0] - a0), 32'd0);

`ifdef WB_RESP_ERR_EN
    // Out-of-range address: error completion, no memory write.
    wren_cnt[0] = 0;
    a0 = ack_cnt[0];
    req(0, 1'b0, 32'h0002_0000, 32'h0, 4'hF);
    req(0, 1'b1, 32'h0002_0000, 32'h5555_5555, 4'hF);
    idle(4);
    chk("err_no_wren", 32'(wren_cnt[0]), 32'd0);
    chk("err_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
    chk("err_mem_intact", mem[0][0], 32'h1000_0000);
`endif

    cyc[0] = 1'b0;
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
